// File: rtl/addrgen_1_a_if.sv
// Pixel-stream and RAM1 port A signal bundle for the write-side address generator.
// The master side owns the pixel source and Arm; the slave side is the generator,
// which drives the RAM port and the frame status flags.
interface addrgen_1_a_if;
    // Pixel source and capture request
    logic        Arm;
    logic        PixValid;
    logic        PixSof;
    logic [7:0]  PixData;

    // RAM1 port A
    logic [17:0] addr_1a;
    logic [7:0]  din_1a;
    logic        we_ram1;
    logic        en_ram1a;

    // Frame status
    logic        FrameDone;
    logic        FrameValid;
    logic        SofErr;

    modport master (
        output Arm, PixValid, PixSof, PixData,
        input  addr_1a, din_1a, we_ram1, en_ram1a, FrameDone, FrameValid, SofErr
    );

    modport slave (
        input  Arm, PixValid, PixSof, PixData,
        output addr_1a, din_1a, we_ram1, en_ram1a, FrameDone, FrameValid, SofErr
    );
endinterface

// File: rtl/addrgen_1_a.sv
// Write-side address generator for frame RAM1 port A.
// Captures an 8-bit pixel stream into linear addresses 0..LAST_ADDR, aligned to
// the start-of-frame marker, and flags frame completion for the read side.
module addrgen_1_a #(
    parameter logic [17:0] LAST_ADDR  = 18'h257FF,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic          clk,
    input  logic          Reset_Main,
    addrgen_1_a_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [17:0] cnt;
    logic [17:0] cnt_nxt;
    logic        wr;
    logic [17:0] wr_addr;
    logic        sof_err_set;
    logic        last;

    // State and write-counter register
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (Reset_Main) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, write decision and write address for the current pixel
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wr          = 1'b0;
        wr_addr     = cnt;
        sof_err_set = 1'b0;

        case (state)
            IDLE: begin
                if (bus.Arm) begin
                    state_nxt = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (bus.PixValid && bus.PixSof) begin
                    wr        = 1'b1;
                    wr_addr   = '0;
                    cnt_nxt   = 18'd1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (bus.PixValid) begin
                    wr = 1'b1;
                    if (bus.PixSof) begin
                        // Early start-of-frame: restart the frame at address 0.
                        wr_addr     = '0;
                        cnt_nxt     = 18'd1;
                        sof_err_set = 1'b1;
                    end else begin
                        wr_addr = cnt;
                        cnt_nxt = cnt + 18'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Writing the final address closes the frame; in continuous mode the
        // generator is ready for the next start-of-frame on the very next cycle.
        last = wr && (wr_addr == LAST_ADDR);
        if (last) begin
            cnt_nxt   = '0;
            state_nxt = CONTINUOUS ? WAIT_SOF : IDLE;
        end
    end

    // Registered RAM port: address and data hold their last value between writes
    always_ff @(posedge clk) begin
        if (Reset_Main) begin
            bus.addr_1a  <= '0;
            bus.din_1a   <= '0;
            bus.we_ram1  <= 1'b0;
            bus.en_ram1a <= 1'b0;
        end else begin
            bus.we_ram1  <= wr;
            bus.en_ram1a <= wr;
            if (wr) begin
                bus.addr_1a <= wr_addr;
                bus.din_1a  <= bus.PixData;
            end
        end
    end

    // Registered frame status: completion pulse plus two sticky flags
    always_ff @(posedge clk) begin
        if (Reset_Main) begin
            bus.FrameDone  <= 1'b0;
            bus.FrameValid <= 1'b0;
            bus.SofErr     <= 1'b0;
        end else begin
            bus.FrameDone  <= last;
            bus.FrameValid <= bus.FrameValid | last;
            bus.SofErr     <= bus.SofErr | sof_err_set;
        end
    end

endmodule
